// File: rtl/mem_arbiter_n.sv
// N-master memory arbiter: one downstream request port, fixed or round-robin grant,
// and an in-flight ID FIFO that routes each ordered response back to its master.
module mem_arbiter_n #(
    parameter int N_MASTERS       = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MASK_WIDTH      = 4,
    parameter int RR_MODE         = 0,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bus_hold_i,
    output logic                             mem_hold_o,
    input  logic [N_MASTERS-1:0]             m_req,
    input  logic [N_MASTERS-1:0]             m_we,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
    input  logic [N_MASTERS*MASK_WIDTH-1:0]  m_wmask,
    output logic [N_MASTERS-1:0]             m_addr_ok,
    output logic [N_MASTERS-1:0]             m_data_ok,
    output logic [N_MASTERS*DATA_WIDTH-1:0]  m_rdata,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic [MASK_WIDTH-1:0]            mem_wmask,
    input  logic                             mem_addr_ok,
    input  logic                             mem_data_ok,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                             err_o
);

    // Handshake: m_req/mem_req act as valid and m_addr_ok/mem_addr_ok as ready; a request
    // transfers in the cycle both are high and the requester holds its fields until then.
    // mem_data_ok is a single-cycle response strobe with no backpressure.

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [IW-1:0] id_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] head_id;
    logic          any_req, fifo_full, fifo_empty, can_issue, accept, pop, err_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scans offsets downward so the smallest offset from rr_ptr wins.
    always_comb begin
        grant = '0;
        if (RR_MODE != 0) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (m_req[(int'(rr_ptr) + i) % N_MASTERS])
                    grant = IW'((int'(rr_ptr) + i) % N_MASTERS);
            end
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (m_req[i]) grant = IW'(i);
            end
        end
    end

    assign any_req    = |m_req;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == MAX_CNT);
    // A response in the same cycle frees the head slot, so a full FIFO can still issue.
    assign can_issue  = !bus_hold_i && (!fifo_full || mem_data_ok);
    assign mem_req    = !rst && can_issue && any_req;
    assign accept     = mem_req && mem_addr_ok;
    assign pop        = !rst && mem_data_ok && !fifo_empty;
    assign head_id    = id_mem[rd_ptr];

    assign mem_hold_o    = bus_hold_i;
    assign outstanding_o = count;
    assign err_o         = err_q;

    always_comb begin
        mem_we      = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        mem_wmask   = '0;
        m_addr_ok   = '0;
        m_data_ok   = '0;
        m_rdata     = '0;
        if (any_req) begin
            mem_we      = m_we[grant];
            mem_address = m_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata   = m_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
            mem_wmask   = m_wmask[grant*MASK_WIDTH +: MASK_WIDTH];
        end
        if (accept) m_addr_ok[grant] = 1'b1;
        if (pop) begin
            m_data_ok[head_id]                      = 1'b1;
            m_rdata[head_id*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) id_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept && RR_MODE != 0)
                rr_ptr <= (grant == IW'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
            if (mem_data_ok && fifo_empty) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: a 2-master fixed-priority instance for directed cases and a
// 4-master round-robin instance driven randomly against an ordered-queue reference model.
module tb_mem_arbiter_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: N=2, fixed priority, MAX_OUTSTANDING=2
    logic        a_hold_i, a_hold_o;
    logic [1:0]  a_req, a_we, a_addr_ok, a_data_ok;
    logic [63:0] a_addr, a_wdata, a_rdata;
    logic [7:0]  a_wmask;
    logic        a_mem_req, a_mem_we, a_mem_addr_ok, a_mem_data_ok;
    logic [31:0] a_mem_address, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_wmask;
    logic [1:0]  a_out;
    logic        a_err;

    // Instance B: N=4, round-robin, MAX_OUTSTANDING=4, 16-bit addresses
    logic         b_hold_i, b_hold_o;
    logic [3:0]   b_req, b_we, b_addr_ok, b_data_ok;
    logic [63:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;
    logic [15:0]  b_wmask;
    logic         b_mem_req, b_mem_we, b_mem_addr_ok, b_mem_data_ok;
    logic [15:0]  b_mem_address;
    logic [31:0]  b_mem_wdata, b_mem_rdata;
    logic [3:0]   b_mem_wmask;
    logic [2:0]   b_out;
    logic         b_err;

    mem_arbiter_n #(.N_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4),
                    .RR_MODE(0), .MAX_OUTSTANDING(2)) dut_a (
        .clk(clk), .rst(rst), .bus_hold_i(a_hold_i), .mem_hold_o(a_hold_o),
        .m_req(a_req), .m_we(a_we), .m_addr(a_addr), .m_wdata(a_wdata), .m_wmask(a_wmask),
        .m_addr_ok(a_addr_ok), .m_data_ok(a_data_ok), .m_rdata(a_rdata),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_address(a_mem_address),
        .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_addr_ok(a_mem_addr_ok),
        .mem_data_ok(a_mem_data_ok), .mem_rdata(a_mem_rdata),
        .outstanding_o(a_out), .err_o(a_err)
    );

    mem_arbiter_n #(.N_MASTERS(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MASK_WIDTH(4),
                    .RR_MODE(1), .MAX_OUTSTANDING(4)) dut_b (
        .clk(clk), .rst(rst), .bus_hold_i(b_hold_i), .mem_hold_o(b_hold_o),
        .m_req(b_req), .m_we(b_we), .m_addr(b_addr), .m_wdata(b_wdata), .m_wmask(b_wmask),
        .m_addr_ok(b_addr_ok), .m_data_ok(b_data_ok), .m_rdata(b_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_address(b_mem_address),
        .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_addr_ok(b_mem_addr_ok),
        .mem_data_ok(b_mem_data_ok), .mem_rdata(b_mem_rdata),
        .outstanding_o(b_out), .err_o(b_err)
    );

    // Reference model state for instance B: IDs in acceptance order and the RR pointer.
    logic [1:0] exp_q[$];
    int         model_ptr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_hold_i = 1'b0; a_req = '0; a_mem_addr_ok = 1'b0; a_mem_data_ok = 1'b0; a_mem_rdata = '0;
        b_hold_i = 1'b0; b_req = '0; b_mem_addr_ok = 1'b0; b_mem_data_ok = 1'b0; b_mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req = 2'b11; a_mem_addr_ok = 1'b1; a_mem_data_ok = 1'b1;
        b_req = 4'b1111; b_mem_addr_ok = 1'b1; b_mem_data_ok = 1'b1;
        tick(); tick();
        #2;
        total++; if (a_mem_req !== 1'b0) begin bad++; $display("FAIL rst_a_mem_req got=%b exp=0", a_mem_req); end
        total++; if (a_addr_ok !== 2'b00) begin bad++; $display("FAIL rst_a_addr_ok got=%b exp=00", a_addr_ok); end
        total++; if (a_data_ok !== 2'b00) begin bad++; $display("FAIL rst_a_data_ok got=%b exp=00", a_data_ok); end
        total++; if (a_out !== 2'd0) begin bad++; $display("FAIL rst_a_out got=%0d exp=0", a_out); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_a_err got=%b exp=0", a_err); end
        total++; if (b_mem_req !== 1'b0 || b_data_ok !== 4'b0) begin bad++; $display("FAIL rst_b_outs got=%b/%b exp=0/0000", b_mem_req, b_data_ok); end
        total++; if (b_out !== 3'd0) begin bad++; $display("FAIL rst_b_out got=%0d exp=0", b_out); end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fixed_priority();
        a_req = 2'b11; a_mem_addr_ok = 1'b1;
        #2;
        total++; if (a_mem_address !== 32'h2000_0004) begin bad++; $display("FAIL fx_addr1 got=%h exp=20000004", a_mem_address); end
        total++; if (a_addr_ok !== 2'b10) begin bad++; $display("FAIL fx_aok1 got=%b exp=10", a_addr_ok); end
        total++; if (a_mem_we !== 1'b1 || a_mem_wmask !== 4'hC || a_mem_wdata !== 32'hBBBB_0001) begin
            bad++; $display("FAIL fx_fields got=%b/%h/%h exp=1/c/bbbb0001", a_mem_we, a_mem_wmask, a_mem_wdata); end
        tick();
        a_req = 2'b01;
        #2;
        total++; if (a_addr_ok !== 2'b01 || a_mem_address !== 32'h1000_0000) begin
            bad++; $display("FAIL fx_m0_after_drop got=%b/%h exp=01/10000000", a_addr_ok, a_mem_address); end
        total++; if (a_out !== 2'd1) begin bad++; $display("FAIL fx_out1 got=%0d exp=1", a_out); end
        tick();
        a_req = 2'b10;
        #2;
        total++; if (a_out !== 2'd2 || a_mem_req !== 1'b0 || a_addr_ok !== 2'b00) begin
            bad++; $display("FAIL fx_full got=%0d/%b/%b exp=2/0/00", a_out, a_mem_req, a_addr_ok); end
        a_mem_data_ok = 1'b1; a_mem_rdata = 32'hCAFE_0001;
        #2;
        total++; if (a_mem_req !== 1'b1 || a_addr_ok !== 2'b10) begin
            bad++; $display("FAIL fx_full_pop_accept got=%b/%b exp=1/10", a_mem_req, a_addr_ok); end
        total++; if (a_data_ok !== 2'b10 || a_rdata !== {32'hCAFE_0001, 32'h0}) begin
            bad++; $display("FAIL fx_resp1 got=%b/%h exp=10/cafe000100000000", a_data_ok, a_rdata); end
        tick();
        a_req = 2'b00; a_mem_rdata = 32'hCAFE_0002;
        #2;
        total++; if (a_out !== 2'd2) begin bad++; $display("FAIL fx_out_stays2 got=%0d exp=2", a_out); end
        total++; if (a_data_ok !== 2'b01 || a_rdata !== {32'h0, 32'hCAFE_0002}) begin
            bad++; $display("FAIL fx_resp2 got=%b/%h exp=01/00000000cafe0002", a_data_ok, a_rdata); end
        tick();
        a_mem_rdata = 32'hCAFE_0003;
        #2;
        total++; if (a_data_ok !== 2'b10) begin bad++; $display("FAIL fx_resp3 got=%b exp=10", a_data_ok); end
        tick();
        a_mem_data_ok = 1'b0; a_mem_addr_ok = 1'b0;
        #2;
        total++; if (a_out !== 2'd0 || a_err !== 1'b0) begin bad++; $display("FAIL fx_drained got=%0d/%b exp=0/0", a_out, a_err); end
    endtask

    task automatic test_empty_err();
        tick();
        a_mem_data_ok = 1'b1;
        #2;
        total++; if (a_data_ok !== 2'b00 || a_err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b/%b exp=00/0", a_data_ok, a_err); end
        tick();
        a_mem_data_ok = 1'b0;
        #2;
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", a_err); end
        tick(); tick();
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", a_err); end
        rst = 1'b1;
        tick();
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", a_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        a_req = 2'b01; a_mem_addr_ok = 1'b1;
        #2;
        total++; if (a_addr_ok !== 2'b01) begin bad++; $display("FAIL hold_pre_accept got=%b exp=01", a_addr_ok); end
        tick();
        a_hold_i = 1'b1;
        #2;
        total++; if (a_mem_req !== 1'b0 || a_hold_o !== 1'b1 || a_addr_ok !== 2'b00) begin
            bad++; $display("FAIL hold_block got=%b/%b/%b exp=0/1/00", a_mem_req, a_hold_o, a_addr_ok); end
        a_mem_data_ok = 1'b1; a_mem_rdata = 32'h0BAD_F00D;
        #2;
        total++; if (a_data_ok !== 2'b01 || a_rdata !== {32'h0, 32'h0BAD_F00D} || a_mem_req !== 1'b0) begin
            bad++; $display("FAIL hold_resp got=%b/%h/%b exp=01/000000000badf00d/0", a_data_ok, a_rdata, a_mem_req); end
        tick();
        a_hold_i = 1'b0; a_mem_data_ok = 1'b0;
        #2;
        total++; if (a_mem_req !== 1'b1 || a_addr_ok !== 2'b01 || a_hold_o !== 1'b0) begin
            bad++; $display("FAIL hold_release got=%b/%b/%b exp=1/01/0", a_mem_req, a_addr_ok, a_hold_o); end
        tick();
        a_req = 2'b00; a_mem_data_ok = 1'b1;
        #2;
        total++; if (a_out !== 2'd1 || a_data_ok !== 2'b01) begin bad++; $display("FAIL hold_drain got=%0d/%b exp=1/01", a_out, a_data_ok); end
        tick();
        a_mem_data_ok = 1'b0; a_mem_addr_ok = 1'b0;
    endtask

    task automatic test_reset_midflight();
        a_req = 2'b10; a_mem_addr_ok = 1'b1;
        tick();
        a_req = 2'b00; rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        total++; if (a_out !== 2'd0) begin bad++; $display("FAIL mid_rst_out got=%0d exp=0", a_out); end
        tick();
        a_mem_data_ok = 1'b1;
        #2;
        total++; if (a_data_ok !== 2'b00) begin bad++; $display("FAIL mid_rst_no_resp got=%b exp=00", a_data_ok); end
        tick();
        a_mem_data_ok = 1'b0; a_mem_addr_ok = 1'b0;
        #2;
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL mid_rst_err got=%b exp=1", a_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        b_addr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        b_req = 4'b1111; b_mem_addr_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b_mem_data_ok = (k > 0);
            b_mem_rdata   = 32'hD000_0000 + 32'(k);
            #2;
            total++; if (b_addr_ok !== 4'(1 << (k % 4)) || b_mem_address !== 16'(16'h1111 * ((k % 4) + 1))) begin
                bad++; $display("FAIL rr_grant%0d got=%b/%h exp=%b", k, b_addr_ok, b_mem_address, 4'(1 << (k % 4))); end
            if (k > 0) begin
                total++; if (b_data_ok !== 4'(1 << ((k - 1) % 4)) || b_rdata[((k - 1) % 4)*32 +: 32] !== 32'hD000_0000 + 32'(k)) begin
                    bad++; $display("FAIL rr_resp%0d got=%b exp=%b", k, b_data_ok, 4'(1 << ((k - 1) % 4))); end
                total++; if (b_out !== 3'd1) begin bad++; $display("FAIL rr_out%0d got=%0d exp=1", k, b_out); end
            end
            tick();
        end
        b_req = 4'b0000; b_mem_data_ok = 1'b1;
        #2;
        total++; if (b_data_ok !== 4'b0001) begin bad++; $display("FAIL rr_last_resp got=%b exp=0001", b_data_ok); end
        tick();
        b_mem_data_ok = 1'b0; b_mem_addr_ok = 1'b0;
        #2;
        total++; if (b_out !== 3'd0) begin bad++; $display("FAIL rr_drained got=%0d exp=0", b_out); end
    endtask

    task automatic test_random_rr();
        bit          pend[4];
        logic [15:0] p_addr[4];
        logic        p_we[4];
        logic [31:0] p_wdata[4];
        logic [3:0]  p_wmask[4];
        logic [127:0] e_rd;
        int g;
        bit can, e_req, acc, d_ok;
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    p_addr[i] = 16'($urandom); p_we[i] = 1'($urandom);
                    p_wdata[i] = $urandom; p_wmask[i] = 4'($urandom);
                end
                b_req[i] = pend[i]; b_we[i] = p_we[i];
                b_addr[i*16 +: 16] = p_addr[i]; b_wdata[i*32 +: 32] = p_wdata[i]; b_wmask[i*4 +: 4] = p_wmask[i];
            end
            b_hold_i      = ($urandom_range(0, 7) == 0);
            b_mem_addr_ok = ($urandom_range(0, 3) != 0);
            d_ok          = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            b_mem_data_ok = d_ok;
            b_mem_rdata   = $urandom;
            #2;
            // First pending master found walking forward from the pointer, wrapping at 4.
            g = -1;
            for (int off = 0; off < 4 && g < 0; off++) if (pend[(model_ptr + off) % 4]) g = (model_ptr + off) % 4;
            can   = !b_hold_i && (exp_q.size() < 4 || d_ok);
            e_req = can && (g >= 0);
            acc   = e_req && b_mem_addr_ok;
            e_rd  = '0;
            if (d_ok) e_rd[int'(exp_q[0])*32 +: 32] = b_mem_rdata;
            total++; if (b_out !== 3'(exp_q.size())) begin bad++; $display("FAIL rnd_out c%0d got=%0d exp=%0d", cyc, b_out, exp_q.size()); end
            total++; if (b_mem_req !== e_req || b_hold_o !== b_hold_i) begin bad++; $display("FAIL rnd_req c%0d got=%b/%b exp=%b", cyc, b_mem_req, b_hold_o, e_req); end
            total++; if (b_addr_ok !== (acc ? 4'(1 << g) : 4'b0)) begin bad++; $display("FAIL rnd_aok c%0d got=%b grant=%0d acc=%b", cyc, b_addr_ok, g, acc); end
            total++; if (b_data_ok !== (d_ok ? 4'(1 << exp_q[0]) : 4'b0) || b_rdata !== e_rd) begin
                bad++; $display("FAIL rnd_resp c%0d got=%b/%h exp_rd=%h", cyc, b_data_ok, b_rdata, e_rd); end
            if (g >= 0) begin
                total++; if (b_mem_address !== p_addr[g] || b_mem_we !== p_we[g] || b_mem_wdata !== p_wdata[g] || b_mem_wmask !== p_wmask[g]) begin
                    bad++; $display("FAIL rnd_fields c%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", cyc, b_mem_address, b_mem_we, b_mem_wdata, b_mem_wmask, p_addr[g], p_we[g], p_wdata[g], p_wmask[g]); end
            end else begin
                total++; if (b_mem_address !== 16'h0 || b_mem_we !== 1'b0) begin bad++; $display("FAIL rnd_idle c%0d got=%h/%b exp=0/0", cyc, b_mem_address, b_mem_we); end
            end
            if (d_ok) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(2'(g));
                pend[g]   = 1'b0;
                model_ptr = (g + 1) % 4;
            end
        end
        tick();
        b_req = '0; b_hold_i = 1'b0; b_mem_addr_ok = 1'b0;
        for (int guard = 0; guard < 8 && exp_q.size() > 0; guard++) begin
            b_mem_data_ok = 1'b1; b_mem_rdata = $urandom;
            #2;
            total++; if (b_data_ok !== 4'(1 << exp_q[0])) begin bad++; $display("FAIL rnd_drain got=%b exp=%b", b_data_ok, 4'(1 << exp_q[0])); end
            void'(exp_q.pop_front());
            tick();
        end
        b_mem_data_ok = 1'b0;
        #2;
        total++; if (b_out !== 3'd0 || b_err !== 1'b0) begin bad++; $display("FAIL rnd_end got=%0d/%b exp=0/0", b_out, b_err); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        a_addr  = {32'h2000_0004, 32'h1000_0000};
        a_we    = 2'b10;
        a_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        a_wmask = {4'hC, 4'h3};
        b_addr = '0; b_we = '0; b_wdata = '0; b_wmask = '0;
        clear_inputs();
        test_reset();
        test_fixed_priority();
        test_empty_err();
        test_hold();
        test_reset_midflight();
        test_round_robin();
        test_random_rr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 Parameter N_MASTERS, default 2: number of requesting masters (2..8); index N_MASTERS-1 corresponds to the data port, index 0 to instruction fetch.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 32: read/write data width.
REQ-004 Parameter MASK_WIDTH, default 4: write byte-mask width.
REQ-005 Parameter RR_MODE, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-006 Parameter MAX_OUTSTANDING, default 2: depth of the in-flight ID FIFO (1..8, power of two).
REQ-007 The block SHALL use one clock; reset is synchronous and active-high.
REQ-008 The ports SHALL be as follows:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- bus_hold_i  in  1  stall request from the bus.
- mem_hold_o  out  1  stall forwarded to the core.
- m_req  in  N_MASTERS  per-master request.
- m_we  in  N_MASTERS  per-master write enable.
- m_addr  in  N_MASTERS*ADDR_WIDTH  packed addresses, master i at slice i.
- m_wdata  in  N_MASTERS*DATA_WIDTH  packed write data.
- m_wmask  in  N_MASTERS*MASK_WIDTH  packed write masks.
- m_addr_ok  out  N_MASTERS  per-master address accepted.
- m_data_ok  out  N_MASTERS  per-master response valid.
- m_rdata  out  N_MASTERS*DATA_WIDTH  packed read data.
- mem_req, mem_we  out  1  downstream request and write enable.
- mem_address  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_WIDTH  downstream write data.
- mem_wmask  out  MASK_WIDTH  downstream write mask.
- mem_addr_ok, mem_data_ok  in  1  downstream handshakes.
- mem_rdata  in  DATA_WIDTH  downstream read data.
- outstanding_o  out  clog2(MAX_OUTSTANDING)+1  in-flight transaction count.
- err_o  out  1  sticky error: a response arrived with nothing in flight.

Function
REQ-009 A master SHALL hold m_req and its request fields stable until it receives m_addr_ok.
REQ-010 Grant SHALL be combinational from m_req: RR_MODE=0 selects the highest-index requester; RR_MODE=1 selects the first requester at or after rr_ptr, wrapping modulo N_MASTERS.
REQ-011 can_issue SHALL equal !bus_hold_i && (!fifo_full || mem_data_ok); a same-cycle pop frees a slot while full.
REQ-012 mem_req SHALL equal can_issue && |m_req.
REQ-013 mem_address, mem_we, mem_wdata and mem_wmask SHALL be taken from the granted master; they are 0 when no master is granted.
REQ-014 Acceptance SHALL be mem_req && mem_addr_ok; on acceptance m_addr_ok[grant]=1 and all other m_addr_ok bits are 0.
REQ-015 On acceptance the grant index SHALL be pushed into the ID FIFO, and in RR_MODE=1 rr_ptr SHALL update to (grant+1) mod N_MASTERS the next cycle.
REQ-016 rr_ptr SHALL be unchanged when no acceptance occurs.
REQ-017 mem_data_ok with a non-empty FIFO SHALL pop the head ID h in the same cycle and drive m_data_ok[h]=1 and m_rdata slice h = mem_rdata.
REQ-018 All non-selected m_data_ok bits SHALL be 0, and all non-selected m_rdata slices SHALL be 0.
REQ-019 Responses SHALL return in acceptance order; write transactions also receive a data_ok response.
REQ-020 mem_data_ok with an empty FIFO SHALL produce no m_data_ok, SHALL set err_o, and err_o SHALL remain 1 until reset.
REQ-021 On a simultaneous push and pop, outstanding_o SHALL be unchanged and the FIFO order SHALL be preserved, including when the FIFO is full.
REQ-022 While bus_hold_i=1, no new acceptances SHALL occur and in-flight responses SHALL still be delivered; mem_hold_o SHALL equal bus_hold_i combinationally.
REQ-023 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-024 outstanding_o SHALL never exceed MAX_OUTSTANDING.

Reset
REQ-025 While rst=1 the block SHALL set: FIFO empty, outstanding_o=0, rr_ptr=0, err_o=0.
REQ-026 While rst=1 the block SHALL drive m_addr_ok=0, m_data_ok=0 and mem_req=0.
REQ-027 Reset asserted mid-transaction SHALL discard in-flight IDs; a later mem_data_ok for a discarded ID sets err_o.

Verification
REQ-028 N=2, fixed mode, m_req=2'b11, mem_addr_ok=1: mem_address = master 1 address, m_addr_ok=2'b10; master 0 is granted only after m_req[1] drops.
REQ-029 N=4, RR mode, all four masters requesting continuously, mem_addr_ok=1: the grant sequence is 0,1,2,3,0; each m_data_ok is returned to the matching master.
REQ-030 MAX_OUTSTANDING=2, two accepts with no mem_data_ok: outstanding_o=2 and mem_req=0; a mem_data_ok cycle with a third request pending accepts and pops in the same cycle, and outstanding_o stays 2.
REQ-031 mem_data_ok pulsed with the FIFO empty: m_data_ok=0 and err_o=1 the next cycle, held until rst.
REQ-032 bus_hold_i=1 with one transaction in flight: mem_req=0, mem_hold_o=1, and the pending response is still delivered; after release, a new accept occurs in the first cycle.
